// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: move commands and move-packet framing helpers.
package tetris_pkg;

    typedef enum logic [1:0] {
        CMD_LEFT   = 2'd0,
        CMD_RIGHT  = 2'd1,
        CMD_DOWN   = 2'd2,
        CMD_ROTATE = 2'd3
    } command_t;

    localparam int unsigned MOVE_PKT_CMD_LSB    = 0;
    localparam int unsigned MOVE_PKT_PIECE_LSB  = 2;
    localparam int unsigned MOVE_PKT_VALID_BIT  = 5;
    localparam int unsigned MOVE_PKT_PARITY_BIT = 7;

    localparam logic [2:0] PIECE_CODE_ALIAS = 3'd7;
    localparam logic [2:0] PIECE_HERO       = 3'd0;

    // Frame one move request; piece code 7 aliases to HERO, bit 7 makes the byte even parity.
    function automatic logic [7:0] encode_move_pkt(command_t cmd, logic [2:0] piece, logic move_valid);
        logic [7:0] pkt;
        logic [2:0] pc;
        pc  = (piece == PIECE_CODE_ALIAS) ? PIECE_HERO : piece;
        pkt = 8'h00;
        pkt[MOVE_PKT_CMD_LSB +: 2]   = cmd;
        pkt[MOVE_PKT_PIECE_LSB +: 3] = pc;
        pkt[MOVE_PKT_VALID_BIT]      = move_valid;
        pkt[MOVE_PKT_PARITY_BIT]     = ^pkt[6:0];
        return pkt;
    endfunction

    // Receiver-side check: a well-formed packet XORs to zero.
    function automatic logic move_pkt_parity_ok(logic [7:0] pkt);
        return ~(^pkt);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                           game_clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (count_q == '0);
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full_q || do_pop_c);
    assign rdata     = mem_q[rd_ptr_q];
    assign full      = full_q;
    assign count     = count_q;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(DEPTH));
    end

    // Pointer and occupancy registers.
    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge game_clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/move_packet_tx.sv
// Frames queued move requests into 8-bit packets and presents them with a level valid/clear handshake.
module move_packet_tx
    import tetris_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                              game_clk,
    input  logic                              reset_n,
    input  logic                              push,
    input  logic [1:0]                        cmd_in,
    input  logic [2:0]                        piece_in,
    input  logic                              move_valid_in,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic [7:0]                        data,
    output logic                              data_valid,
    input  logic                              clear,
    output logic [7:0]                        drop_count
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_RELEASE = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       drop_q, drop_d;
    logic [7:0]       pkt_c;
    logic [7:0]       fifo_rdata;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop_c;

    assign pkt_c = encode_move_pkt(command_t'(cmd_in), piece_in, move_valid_in);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .game_clk (game_clk),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop_c),
        .wdata    (pkt_c),
        .rdata    (fifo_rdata),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (count)
    );

    assign full       = fifo_full;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign drop_count = drop_q;

    // State register.
    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (clear) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!clear) begin
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath controls: pop, packet latch, valid, gap counter, drop counter.
    always_comb begin
        pop_c        = 1'b0;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        gap_d        = gap_q;
        drop_d       = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c        = 1'b1;
                    data_d       = fifo_rdata;
                    data_valid_d = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (clear) begin
                    data_valid_d = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (!clear) begin
                    gap_d = GAP_W'(GAP_CYCLES);
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                data_valid_d = 1'b0;
            end
        endcase
        if (push && fifo_full && !pop_c && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Output and counter registers.
    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            gap_q        <= '0;
            drop_q       <= 8'h00;
        end else begin
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            gap_q        <= gap_d;
            drop_q       <= drop_d;
        end
    end

endmodule

// File: doc/move_packet_tx.md
# move_packet_tx

Transmit-side counterpart of the SPI move-command receiver. Game-side requesters (autoplay, replay, demo sequencer) push move/piece requests into a small FIFO. The block frames each request into the 8-bit move packet the executioner path consumes, then presents it with a level valid/clear handshake identical to the SPI receiver's `data`/`data_valid`/`clear` contract. It can therefore substitute for, or be muxed against, the SPI receiver in front of `game_executioner`.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: request FIFO entries; power of two, at least 2.
- `GAP_CYCLES`, 2: idle `game_clk` cycles enforced after `clear` falls before the next packet is presented; 0 is legal.

Ports:
- `game_clk`  in  1  block clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `push`  in  1  enqueue request this cycle.
- `cmd_in`  in  2  `tetris_pkg::command_t` move.
- `piece_in`  in  3  piece code 0..6; code 7 is encoded as 0 (HERO).
- `move_valid_in`  in  1  value for packet bit 5.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `count`  out  `$clog2(FIFO_DEPTH+1)`  queued entries, excluding the packet being presented.
- `data`  out  8  framed packet.
- `data_valid`  out  1  `data` is valid and stable.
- `clear`  in  1  consumer acknowledge; level signal, may stay high for many cycles.
- `drop_count`  out  8  requests lost to a full FIFO; saturates at 255.

## Operation
Packet format:
- [1:0] = cmd.
- [4:2] = piece.
- [5] = move_valid.
- [6] = 0.
- [7] = even parity over [6:0], so XOR of all 8 bits is 0.

Framing is done at enqueue time; the FIFO stores 8-bit packets.

FSM, states `IDLE`, `PRESENT`, `RELEASE`, `GAP`:
- `IDLE`: if the FIFO is non-empty, pop it, register the packet into `data`, set `data_valid`, and go to `PRESENT`.
- `PRESENT`: hold `data` and `data_valid` stable. On `clear`=1, drop `data_valid` and go to `RELEASE`.
- `RELEASE`: wait for `clear`=0. Then go to `GAP` and load the gap counter with `GAP_CYCLES`. If `GAP_CYCLES`=0, go straight to `IDLE`.
- `GAP`: decrement the counter each cycle and go to `IDLE` when it reaches 0.

Boundary rules:
- **Push with FIFO not full:** the request is accepted.
- **Push with FIFO full:** the request is accepted if the FSM pops in the same cycle. Otherwise it is dropped and `drop_count` increments, saturating.
- **Push with FIFO empty in `IDLE`:** no bypass. The request goes through the FIFO.
- **`clear` already high in `IDLE`:** no effect. A packet presented while `clear` is still high is acknowledged on the next cycle.
- **`data` outside `PRESENT`:** retains the last packet, with `data_valid`=0.
- **Reset at any point, including mid-`PRESENT`:** the FIFO is emptied and the FSM goes to `IDLE`. Reset values are `data`=0, `data_valid`=0, `count`=0, `full`=0, `drop_count`=0, gap counter 0.

## Timing
- `push` is sampled at edge N and the entry is written at edge N.
- The FSM pops at edge N+1.
- `data_valid`=1 is visible after edge N+1, so latency is 2 cycles from the push edge.
- `clear` is sampled at edge M; `data_valid`=0 is visible after edge M.
- `clear` falls, sampled at edge R, moving the FSM to `GAP` at R.
- The next `data_valid` rises after edge R+`GAP_CYCLES`+1.
- Minimum packet period with `clear` held one cycle and `GAP_CYCLES`=2 is 5 cycles.
- `count` and `full` update the cycle after the push or pop edge. A simultaneous push and pop leaves `count` unchanged.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Add to `tetris_pkg`:
  - bit-position constants `MOVE_PKT_CMD_LSB`=0, `MOVE_PKT_PIECE_LSB`=2, `MOVE_PKT_VALID_BIT`=5, `MOVE_PKT_PARITY_BIT`=7;
  - a `function automatic logic [7:0] encode_move_pkt(command_t, logic [2:0], logic)`, shared with the receiver-side parity check.
- The FSM state enum stays local to the module.
- One sub-module, `sync_fifo`:
  - ports: width, depth, `push`, `pop`, `wdata`, `rdata`, `empty`, `full`, `count`;
  - simultaneous push and pop when full is legal.

## Test plan
- Reset, then push cmd=2'b01, piece=3, move_valid=1: `data`=8'h2D (the bit-7 parity of 7'h2D is 0) with `data_valid` high 2 cycles after the push, stable until `clear`.
- Piece code 7 with cmd=0 and move_valid=0: `data`=8'h00.
- Push 10 requests back-to-back with `clear` held low and `FIFO_DEPTH`=8:
  - first packet presented, `full` asserted;
  - 1 request dropped and `drop_count`=1;
  - after acknowledging everything, the 9 presented packets appear in order.
- `clear` held high for 6 cycles on packet A, with B queued: `data_valid` falls 1 cycle after `clear` rises and B appears exactly `GAP_CYCLES`+1 cycles after `clear` falls.
- Assert `reset_n`=0 during `PRESENT` with 3 queued: `data_valid`, `count` and `drop_count` are all 0 the next cycle, and a fresh push presents after 2 cycles.
- Apply 300 pushes while stalled: `drop_count` saturates at 255 and does not wrap.
